// File: rtl/jtag_pkg.sv
// Shared types and defaults for the 1149.1 TAP controller and its BSR chain.
package jtag_pkg;

  localparam int unsigned IR_WIDTH_DEF = 4;
  localparam logic [31:0] IDCODE_DEF   = 32'h1000_0001;

  localparam logic [3:0] OPC_EXTEST = 4'h0;
  localparam logic [3:0] OPC_SAMPLE = 4'h1;
  localparam logic [3:0] OPC_IDCODE = 4'h2;
  localparam logic [3:0] OPC_BYPASS = 4'hF;

  typedef enum logic [3:0] {
    StTestLogicReset = 4'h0,
    StRunTestIdle    = 4'h1,
    StSelectDrScan   = 4'h2,
    StCaptureDr      = 4'h3,
    StShiftDr        = 4'h4,
    StExit1Dr        = 4'h5,
    StPauseDr        = 4'h6,
    StExit2Dr        = 4'h7,
    StUpdateDr       = 4'h8,
    StSelectIrScan   = 4'h9,
    StCaptureIr      = 4'hA,
    StShiftIr        = 4'hB,
    StExit1Ir        = 4'hC,
    StPauseIr        = 4'hD,
    StExit2Ir        = 4'hE,
    StUpdateIr       = 4'hF
  } tap_state_t;

  typedef struct packed {
    logic tlr;
    logic capture_dr;
    logic shift_dr;
    logic update_dr;
    logic capture_ir;
    logic shift_ir;
    logic update_ir;
  } tap_dec_t;

endpackage

// File: rtl/jtag_if.sv
// Boundary-scan chain bundle between the TAP controller (master) and the bsr_cell chain (slave).
interface jtag_if;
  logic tdi;
  logic tdo;
  logic clk_dr;
  logic shift_dr;
  logic update_dr;
  logic mode;
  logic reset;
  logic enable;

  modport master (
    output tdi, clk_dr, shift_dr, update_dr, mode, reset, enable,
    input  tdo
  );

  modport slave (
    input  tdi, clk_dr, shift_dr, update_dr, mode, reset, enable,
    output tdo
  );
endinterface

// File: rtl/jtag_tap_fsm.sv
// 16-state IEEE 1149.1 TAP state machine: state register, tms-driven next state, one-hot decodes.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       reset,
  input  logic       tms,
  output tap_state_t state,
  output tap_dec_t   dec
);

  tap_state_t state_d, state_q;

  always_ff @(posedge tck) begin
    if (!reset) state_q <= StTestLogicReset;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StTestLogicReset: state_d = tms ? StTestLogicReset : StRunTestIdle;
      StRunTestIdle:    state_d = tms ? StSelectDrScan   : StRunTestIdle;
      StSelectDrScan:   state_d = tms ? StSelectIrScan   : StCaptureDr;
      StCaptureDr:      state_d = tms ? StExit1Dr        : StShiftDr;
      StShiftDr:        state_d = tms ? StExit1Dr        : StShiftDr;
      StExit1Dr:        state_d = tms ? StUpdateDr       : StPauseDr;
      StPauseDr:        state_d = tms ? StExit2Dr        : StPauseDr;
      StExit2Dr:        state_d = tms ? StUpdateDr       : StShiftDr;
      StUpdateDr:       state_d = tms ? StSelectDrScan   : StRunTestIdle;
      StSelectIrScan:   state_d = tms ? StTestLogicReset : StCaptureIr;
      StCaptureIr:      state_d = tms ? StExit1Ir        : StShiftIr;
      StShiftIr:        state_d = tms ? StExit1Ir        : StShiftIr;
      StExit1Ir:        state_d = tms ? StUpdateIr       : StPauseIr;
      StPauseIr:        state_d = tms ? StExit2Ir        : StPauseIr;
      StExit2Ir:        state_d = tms ? StUpdateIr       : StShiftIr;
      StUpdateIr:       state_d = tms ? StSelectDrScan   : StRunTestIdle;
      default:          state_d = StTestLogicReset;
    endcase
  end

  always_comb begin
    dec            = '0;
    dec.tlr        = (state_q == StTestLogicReset);
    dec.capture_dr = (state_q == StCaptureDr);
    dec.shift_dr   = (state_q == StShiftDr);
    dec.update_dr  = (state_q == StUpdateDr);
    dec.capture_ir = (state_q == StCaptureIr);
    dec.shift_ir   = (state_q == StShiftIr);
    dec.update_ir  = (state_q == StUpdateIr);
  end

  assign state = state_q;

endmodule

// File: rtl/jtag_tap_controller.sv
// TAP controller: IR, bypass and IDCODE registers, register select, BSR strobe gating and tdo mux.
module jtag_tap_controller
  import jtag_pkg::*;
#(
  parameter int unsigned          IR_WIDTH   = IR_WIDTH_DEF,
  parameter logic [31:0]          IDCODE_VAL = IDCODE_DEF,
  parameter logic [IR_WIDTH-1:0]  OP_EXTEST  = IR_WIDTH'(OPC_EXTEST),
  parameter logic [IR_WIDTH-1:0]  OP_SAMPLE  = IR_WIDTH'(OPC_SAMPLE),
  parameter logic [IR_WIDTH-1:0]  OP_IDCODE  = IR_WIDTH'(OPC_IDCODE),
  parameter logic [IR_WIDTH-1:0]  OP_BYPASS  = IR_WIDTH'(OPC_BYPASS)
) (
  input  logic       tck,
  input  logic       reset,
  input  logic       tms,
  input  logic       tdi,
  output logic       tdo,
  output logic       tdo_en,
  jtag_if.master     bsr
);

  tap_state_t state;
  tap_dec_t   dec;

  logic [IR_WIDTH-1:0] ir_q, ir_sr_q;
  logic [31:0]         idcode_sr_q;
  logic                bypass_q;
  logic                bsr_sel, id_sel, byp_sel, dr_en, active;

  jtag_tap_fsm u_fsm (
    .tck   (tck),
    .reset (reset),
    .tms   (tms),
    .state (state),
    .dec   (dec)
  );

  // Undefined opcodes fall through to bypass; OP_BYPASS needs no explicit match.
  assign bsr_sel = (ir_q == OP_EXTEST) || (ir_q == OP_SAMPLE);
  assign id_sel  = (ir_q == OP_IDCODE);
  assign byp_sel = !bsr_sel && !id_sel;

  always_ff @(posedge tck) begin
    if (!reset) begin
      ir_q        <= OP_IDCODE;
      ir_sr_q     <= '0;
      bypass_q    <= 1'b0;
      idcode_sr_q <= '0;
    end else begin
      if (dec.tlr)            ir_q <= OP_IDCODE;
      else if (dec.update_ir) ir_q <= ir_sr_q;

      if (dec.capture_ir)    ir_sr_q <= {{(IR_WIDTH-2){1'b0}}, 2'b01};
      else if (dec.shift_ir) ir_sr_q <= {tdi, ir_sr_q[IR_WIDTH-1:1]};

      if (dec.capture_dr) begin
        if (id_sel)  idcode_sr_q <= IDCODE_VAL;
        if (byp_sel) bypass_q    <= 1'b0;
      end else if (dec.shift_dr) begin
        if (id_sel)  idcode_sr_q <= {tdi, idcode_sr_q[31:1]};
        if (byp_sel) bypass_q    <= tdi;
      end
    end
  end

  // Everything toward the chain is quiet while reset is held or the FSM sits in TLR.
  assign active = reset && !dec.tlr;
  assign dr_en  = (dec.capture_dr || dec.shift_dr) && bsr_sel;

  // Gated strobes rise on negedge tck; clk_dr falls on the posedge that advances the FSM.
  assign bsr.clk_dr    = ~tck & reset & dr_en;
  assign bsr.update_dr = ~tck & reset & dec.update_dr & bsr_sel;
  assign bsr.shift_dr  = reset & dec.shift_dr;
  assign bsr.mode      = active & (ir_q == OP_EXTEST);
  assign bsr.reset     = active;
  assign bsr.enable    = active;
  assign bsr.tdi       = tdi;

  assign tdo_en = reset & (dec.shift_dr | dec.shift_ir);

  always_comb begin
    tdo = 1'b0;
    if (reset) begin
      case (state)
        StShiftIr: tdo = ir_sr_q[0];
        StShiftDr: tdo = bsr_sel ? bsr.tdo : (id_sel ? idcode_sr_q[0] : bypass_q);
        default:   tdo = 1'b0;
      endcase
    end
  end

endmodule
